aes_sbox_array: RTL

//   Multi-lane, pipelined AES byte-substitution engine. Applies the forward S-box (SubBytes/SubWord)
//   or inverse S-box (InvSubBytes) to LANES bytes in parallel, with an elastic valid/ready pipeline.

---
 rtl/aes_sbox_array.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/aes_sbox_array.sv
// Multi-lane pipelined AES S-box: forward/inverse byte substitution on LANES bytes per beat,
// with an elastic valid/ready pipeline of PIPE_STAGES registers and no skid buffer.
module aes_sbox_array #(
  parameter int LANES       = 16,
  parameter int PIPE_STAGES = 2,
  parameter int INV_EN      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_inv,
  output logic               busy
);

  localparam int W    = 8 * LANES;
  localparam int LAST = PIPE_STAGES - 1;

  // Tables are held as constants so each lane is a pure combinational ROM with no load step.
  localparam logic [0:255][7:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         inv_sel;
  logic [W-1:0] sub_data;

  assign inv_sel = (INV_EN != 0) ? in_inv : 1'b0;

  generate
    if (INV_EN != 0) begin : g_inv
      localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
      };
      for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign sub_data[8*i +: 8] = inv_sel ? INV_SBOX[in_data[8*i +: 8]]
                                            : FWD_SBOX[in_data[8*i +: 8]];
      end
    end else begin : g_fwd
      for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign sub_data[8*i +: 8] = FWD_SBOX[in_data[8*i +: 8]];
      end
    end
  endgenerate

  logic [PIPE_STAGES-1:0] stg_vld;
  logic [PIPE_STAGES-1:0] stg_inv;
  logic [PIPE_STAGES-1:0] stg_load;
  logic [PIPE_STAGES-1:0] src_vld;
  logic [PIPE_STAGES-1:0] src_inv;
  logic [W-1:0]           stg_data [PIPE_STAGES];
  logic [W-1:0]           src_data [PIPE_STAGES];

  // Stage 0 is fed by the lookup, every later stage by its predecessor.
  generate
    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_src
      if (k == 0) begin : g_head
        assign src_vld[k]  = in_valid;
        assign src_inv[k]  = inv_sel;
        assign src_data[k] = sub_data;
      end else begin : g_body
        assign src_vld[k]  = stg_vld[k-1];
        assign src_inv[k]  = stg_inv[k-1];
        assign src_data[k] = stg_data[k-1];
      end
    end
  endgenerate

  // A stage may load when it is empty or its content moves on this cycle; the ready
  // decision ripples from out_ready back to the input.
  always_comb begin : load_chain
    logic drain;
    // NOTE: blocking assignments here model a combinational chain; 'drain' carries the
    // downstream load decision from one stage to the next within the same evaluation.
    drain    = out_ready;
    stg_load = '0;
    for (int k = LAST; k >= 0; k--) begin
      stg_load[k] = !stg_vld[k] || drain;
      drain       = stg_load[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld <= '0;
      stg_inv <= '0;
      // NOTE: the data registers are cleared too so out_data reads zero straight after reset;
      // they are registers, not a RAM, so the reset costs only the flop type.
      for (int k = 0; k < PIPE_STAGES; k++) begin
        stg_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (stg_load[k]) begin
          stg_vld[k] <= src_vld[k];
          if (src_vld[k]) begin
            stg_data[k] <= src_data[k];
            stg_inv[k]  <= src_inv[k];
          end
        end
      end
    end
  end

  assign in_ready  = stg_load[0] && !rst;
  assign out_valid = stg_vld[LAST];
  assign out_data  = stg_data[LAST];
  assign out_inv   = stg_inv[LAST];
  assign busy      = |stg_vld;

endmodule
